// File: rtl/imc_bus_pkg.sv
// Shared definitions for the in-memory-compute wishbone initiator: FSM states,
// default bus timing and the width of the transaction cycle counter.
package imc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE_WR = 2'd1,
        DRIVE_RD = 2'd2,
        RESP     = 2'd3
    } state_e;

    localparam int unsigned DEF_RD_WAIT = 4;
    localparam int unsigned DEF_WR_HOLD = 2;
    localparam int unsigned CNT_W       = 8;

    // The counter runs from cycles-1 down to 0, so a load of N-1 gives N drive cycles.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/imc_wb_initiator.sv
// Single-outstanding command-to-wishbone initiator for the in-memory-compute array:
// writes hold the bus for WR_HOLD cycles, reads/computes drive for RD_WAIT cycles then respond.
module imc_wb_initiator
    import imc_bus_pkg::*;
#(
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_HOLD = DEF_WR_HOLD
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic        cmd_compute,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [15:0] rsp_csa,
    output logic [2:0]  rsp_adc,

    output logic [31:0] wishbone_address_bus,
    output logic [31:0] wishbone_data_in,
    output logic        wbs_we_i,
    output logic        enable_IM,
    input  logic [31:0] wishbone_data_out,
    input  logic [15:0] CSA,
    input  logic [2:0]  ADC_OUT_OBS,

    output logic        busy
);

    localparam logic [CNT_W-1:0] RD_LOAD = cnt_load(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD = cnt_load(WR_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]      addr_q,    addr_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic             compute_q, compute_d;
    logic [31:0]      rdata_q,   rdata_d;
    logic [15:0]      csa_q,     csa_d;
    logic [2:0]       adc_q,     adc_d;
    logic             cnt_done;

    assign cnt_done = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        compute_d = compute_q;
        rdata_d   = rdata_q;
        csa_d     = csa_q;
        adc_d     = adc_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    // A write never enables compute, even if cmd_compute is set.
                    compute_d = cmd_compute & ~cmd_we;
                    if (cmd_we) begin
                        state_d = DRIVE_WR;
                        cnt_d   = WR_LOAD;
                    end else begin
                        state_d = DRIVE_RD;
                        cnt_d   = RD_LOAD;
                    end
                end
            end

            DRIVE_WR: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            DRIVE_RD: begin
                if (cnt_done) begin
                    state_d = RESP;
                    rdata_d = wishbone_data_out;
                    csa_d   = CSA;
                    adc_d   = ADC_OUT_OBS;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            compute_q <= 1'b0;
            rdata_q   <= '0;
            csa_q     <= '0;
            adc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            compute_q <= compute_d;
            rdata_q   <= rdata_d;
            csa_q     <= csa_d;
            adc_q     <= adc_d;
        end
    end

    // cmd_ready is gated by rst so every output reads zero while reset is held.
    assign cmd_ready            = (state_q == IDLE) && !rst;
    assign busy                 = (state_q != IDLE);
    assign rsp_valid            = (state_q == RESP);
    assign wbs_we_i             = (state_q == DRIVE_WR);
    assign enable_IM            = (state_q == DRIVE_RD) && compute_q;
    assign wishbone_address_bus = addr_q;
    assign wishbone_data_in     = wdata_q;
    assign rsp_rdata            = rdata_q;
    assign rsp_csa              = csa_q;
    assign rsp_adc              = adc_q;

endmodule

// File: tb/tb_imc_wb_initiator.sv
// Bench for imc_wb_initiator: timestamp-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_imc_wb_initiator;

    localparam int unsigned RD_WAIT = 4;
    localparam int unsigned WR_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic        cmd_compute = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [15:0] rsp_csa;
    logic [2:0]  rsp_adc;
    logic [31:0] wishbone_address_bus;
    logic [31:0] wishbone_data_in;
    logic        wbs_we_i;
    logic        enable_IM;
    logic [31:0] wishbone_data_out = '0;
    logic [15:0] CSA = '0;
    logic [2:0]  ADC_OUT_OBS = '0;
    logic        busy;

    imc_wb_initiator #(.RD_WAIT(RD_WAIT), .WR_HOLD(WR_HOLD)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_compute(cmd_compute), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_csa(rsp_csa), .rsp_adc(rsp_adc),
        .wishbone_address_bus(wishbone_address_bus), .wishbone_data_in(wishbone_data_in),
        .wbs_we_i(wbs_we_i), .enable_IM(enable_IM), .wishbone_data_out(wishbone_data_out),
        .CSA(CSA), .ADC_OUT_OBS(ADC_OUT_OBS), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted command occupies the bus from its accept edge for
    // HOLD/WAIT edges; a read then owns a pending response until the rsp handshake edge.
    int          e = 0;
    int          t_acc = 0;
    bit          m_act = 1'b0, m_wr = 1'b0, m_cmp = 1'b0, m_resp = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;
    logic [15:0] m_csa = '0;
    logic [2:0]  m_adc = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0; m_wr <= 1'b0; m_cmp <= 1'b0; m_resp <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_rd <= '0; m_csa <= '0; m_adc <= '0;
        end else begin
            e <= e + 1;
            if (m_resp && rsp_ready) m_resp <= 1'b0;
            if (m_act && ((e + 1 - t_acc) == int'(m_wr ? WR_HOLD : RD_WAIT))) begin
                m_act <= 1'b0;
                if (!m_wr) begin
                    m_resp <= 1'b1;
                    m_rd   <= wishbone_data_out;
                    m_csa  <= CSA;
                    m_adc  <= ADC_OUT_OBS;
                end
            end
            if (!m_act && !m_resp && cmd_valid) begin
                m_act   <= 1'b1;
                t_acc   <= e + 1;
                m_wr    <= cmd_we;
                m_cmp   <= cmd_compute && !cmd_we;
                m_addr  <= cmd_addr;
                m_wdata <= cmd_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(!rst && !m_act && !m_resp));
            chk("busy",      32'(busy),      32'(m_act || m_resp));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
            chk("wbs_we_i",  32'(wbs_we_i),  32'(m_act && m_wr));
            chk("enable_IM", 32'(enable_IM), 32'(m_act && !m_wr && m_cmp));
            chk("addr_bus",  wishbone_address_bus, m_addr);
            chk("wdata_bus", wishbone_data_in, m_wdata);
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_csa",   32'(rsp_csa), 32'(m_csa));
            chk("rsp_adc",   32'(rsp_adc), 32'(m_adc));
        end
    end

    // Results of the most recent observation window.
    int          o_we, o_en, o_rdy_at, o_rdy_n, o_vld_at, o_vld_n, o_unstable;
    logic [31:0] o_bus_a, o_bus_d, o_rd;
    logic [15:0] o_cs;
    logic [2:0]  o_ad;

    task automatic issue(input logic we, input logic comp, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_compute = comp; cmd_addr = a; cmd_wdata = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Watches n cycles starting with the current one; array inputs are inverted in
    // cycle 6 so a response still pending then must not follow them.
    task automatic observe(input int n);
        o_we = 0; o_en = 0; o_rdy_at = -1; o_rdy_n = 0; o_vld_at = -1; o_vld_n = 0; o_unstable = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i == 6) begin
                wishbone_data_out = ~wishbone_data_out; CSA = ~CSA; ADC_OUT_OBS = ~ADC_OUT_OBS;
            end
            @(negedge clk);
            if (i == 0) begin o_bus_a = wishbone_address_bus; o_bus_d = wishbone_data_in; end
            if (wbs_we_i) o_we++;
            if (enable_IM) o_en++;
            if (cmd_ready) begin o_rdy_n++; if (o_rdy_at < 0) o_rdy_at = i; end
            if (rsp_valid) begin
                o_vld_n++;
                if (o_vld_at < 0) begin
                    o_vld_at = i; o_rd = rsp_rdata; o_cs = rsp_csa; o_ad = rsp_adc;
                end else if (rsp_rdata !== o_rd || rsp_csa !== o_cs || rsp_adc !== o_ad) begin
                    o_unstable++;
                end
            end
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {27'd0, cmd_ready, busy, rsp_valid, wbs_we_i, enable_IM}, 32'd0);
        @(posedge clk); @(negedge clk); #1 rst = 1'b0;
        #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Plain write.
        rsp_ready = 1'b1;
        issue(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        observe(6);
        chk("wr_we_cycles", 32'(o_we), 32'd2);
        chk("wr_addr", o_bus_a, 32'h0000_0010);
        chk("wr_data", o_bus_d, 32'hDEAD_BEEF);
        chk("wr_no_rsp", 32'(o_vld_n), 32'd0);
        chk("wr_ready_return", 32'(o_rdy_at), 32'd2);

        // Plain read.
        wishbone_data_out = 32'h1234_5678; CSA = 16'hA5A5; ADC_OUT_OBS = 3'b101;
        issue(1'b0, 1'b0, 32'h0000_0020, 32'h0);
        observe(7);
        chk("rd_latency", 32'(o_vld_at), 32'd4);
        chk("rd_rdata", o_rd, 32'h1234_5678);
        chk("rd_csa", 32'(o_cs), 32'h0000_A5A5);
        chk("rd_adc", 32'(o_ad), 32'd5);
        chk("rd_no_enable", 32'(o_en), 32'd0);
        chk("rd_addr", o_bus_a, 32'h0000_0020);
        chk("rd_ready_return", 32'(o_rdy_at), 32'd5);

        // Compute read with the consumer stalling.
        rsp_ready = 1'b0;
        wishbone_data_out = 32'hCAFE_F00D; CSA = 16'h5A5A; ADC_OUT_OBS = 3'b010;
        issue(1'b0, 1'b1, 32'h0000_0040, 32'h0);
        observe(16);
        chk("cmp_enable_cycles", 32'(o_en), 32'd4);
        chk("cmp_latency", 32'(o_vld_at), 32'd4);
        chk("cmp_rdata", o_rd, 32'hCAFE_F00D);
        chk("cmp_unstable", 32'(o_unstable), 32'd0);
        chk("cmp_ready_cycles", 32'(o_rdy_n), 32'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("cmp_ready_before_hs", 32'(cmd_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("cmp_ready_after_hs", 32'(cmd_ready), 32'd1);
        chk("cmp_valid_after_hs", 32'(rsp_valid), 32'd0);

        // Write with compute set.
        issue(1'b1, 1'b1, 32'h0000_0080, 32'h0BAD_CAFE);
        observe(6);
        chk("wrc_no_enable", 32'(o_en), 32'd0);
        chk("wrc_we_cycles", 32'(o_we), 32'd2);
        chk("wrc_no_rsp", 32'(o_vld_n), 32'd0);

        // Reset during the second read drive cycle.
        issue(1'b0, 1'b0, 32'h0000_0100, 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_ctrl_zero", {27'd0, cmd_ready, busy, rsp_valid, wbs_we_i, enable_IM}, 32'd0);
        chk("rst_addr_zero", wishbone_address_bus, 32'd0);
        chk("rst_rsp_zero", rsp_rdata | {16'd0, rsp_csa} | {29'd0, rsp_adc}, 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        #1 chk("rst_ready_first", 32'(cmd_ready), 32'd1);
        observe(6);
        chk("rst_no_rsp", 32'(o_vld_n), 32'd0);
        wishbone_data_out = 32'h0BAD_F00D; CSA = 16'h1357; ADC_OUT_OBS = 3'b011;
        issue(1'b0, 1'b0, 32'h0000_0200, 32'h0);
        observe(6);
        chk("post_rst_latency", 32'(o_vld_at), 32'd4);
        chk("post_rst_rdata", o_rd, 32'h0BAD_F00D);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            cmd_valid         = ($urandom_range(0, 99) < 60);
            cmd_we            = 1'($urandom_range(0, 1));
            cmd_compute       = 1'($urandom_range(0, 1));
            cmd_addr          = $urandom;
            cmd_wdata         = $urandom;
            rsp_ready         = ($urandom_range(0, 99) < 50);
            wishbone_data_out = $urandom;
            CSA               = 16'($urandom);
            ADC_OUT_OBS       = 3'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                @(negedge clk); #1 rst = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imc_wb_initiator.md
IMC_WB_INITIATOR -- requirements
Module: imc_wb_initiator

Interface
REQ-001 Parameter RD_WAIT, default 4: number of cycles a read or compute transaction drives the bus before capture; legal range 1..255.
REQ-002 Parameter WR_HOLD, default 2: number of cycles a write transaction drives the bus; legal range 1..255.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command-side request.
REQ-006 cmd_ready  out  1  high only in IDLE.
REQ-007 cmd_we  in  1  1 = write, 0 = read.
REQ-008 cmd_compute  in  1  read with enable_IM asserted (in-memory compute).
REQ-009 cmd_addr  in  32  target address.
REQ-010 cmd_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumer accept.
REQ-013 rsp_rdata  out  32  captured wishbone_data_out.
REQ-014 rsp_csa  out  16  captured CSA.
REQ-015 rsp_adc  out  3  captured ADC_OUT_OBS.
REQ-016 wishbone_address_bus  out  32  address to the array wrapper.
REQ-017 wishbone_data_in  out  32  write data to the array wrapper.
REQ-018 wbs_we_i  out  1  write strobe to the array wrapper.
REQ-019 enable_IM  out  1  in-memory-compute enable.
REQ-020 wishbone_data_out  in  32  read data from the array wrapper.
REQ-021 CSA  in  16  sense-amp outputs; ADC_OUT_OBS  in  3  ADC observation bits.
REQ-022 busy  out  1  high in any state other than IDLE.

Function
REQ-023 The FSM SHALL have four states: IDLE, DRIVE_WR, DRIVE_RD, RESP.
REQ-024 A command SHALL be accepted on the edge where cmd_valid && cmd_ready; acceptance registers addr, wdata, we, and compute, and loads the cycle counter.
REQ-025 If cmd_we=1, the FSM SHALL go IDLE->DRIVE_WR; wbs_we_i=1 for exactly WR_HOLD cycles, then IDLE; no response is produced.
REQ-026 If cmd_we=1 and cmd_compute=1, the command SHALL be treated as a plain write; enable_IM stays 0.
REQ-027 If cmd_we=0, the FSM SHALL go IDLE->DRIVE_RD for exactly RD_WAIT cycles; enable_IM=cmd_compute throughout DRIVE_RD.
REQ-028 On the edge ending the last DRIVE_RD cycle, the block SHALL capture wishbone_data_out, CSA, and ADC_OUT_OBS into rsp_* and enter RESP with rsp_valid=1.
REQ-029 Read latency SHALL be: accept at edge k; bus driven in cycles k+1..k+RD_WAIT; rsp_valid high from cycle k+RD_WAIT+1.
REQ-030 rsp_* SHALL be held stable while rsp_valid && !rsp_ready; RESP->IDLE on rsp_valid && rsp_ready.
REQ-031 cmd_ready SHALL be 0 in DRIVE_WR, DRIVE_RD, and RESP, so there is one transaction outstanding at most.
REQ-032 Outside DRIVE states, wbs_we_i and enable_IM SHALL be 0; wishbone_address_bus and wishbone_data_in SHALL hold their last driven values.
REQ-033 The cycle counter SHALL be 8 bits; it loads the parameter value minus 1 on accept and leaves the DRIVE state when it reaches 0, with no wrap-around.
REQ-034 Back-to-back operation: a command presented in the cycle IDLE is re-entered SHALL be accepted on that edge, with no bubble beyond the mandatory IDLE cycle.

Reset
REQ-035 When rst is asserted, all outputs SHALL go low or zero immediately, the FSM SHALL enter IDLE, and the counter and capture registers SHALL clear; a transaction in flight is discarded with no response.
REQ-036 After rst deasserts, cmd_ready SHALL be 1 in the first cycle.

Structure
REQ-037 A shared package imc_bus_pkg SHALL hold the state enumeration, the default RD_WAIT and WR_HOLD constants, and the counter width constant.
REQ-038 The block SHALL be a single module with no sub-module; the counter and capture registers are inline.

Verification
REQ-039 Write addr=0x0000_0010, wdata=0xDEAD_BEEF -> wbs_we_i high for exactly 2 cycles with those bus values, rsp_valid never asserts, and cmd_ready returns in cycle 3.
REQ-040 Read addr=0x20 with wishbone_data_out=0x1234_5678, CSA=0xA5A5, ADC_OUT_OBS=3'b101 -> rsp_valid in cycle 5 after accept, carrying exactly those values, and enable_IM=0.
REQ-041 Compute read with rsp_ready held 0 for 10 cycles -> enable_IM high for exactly 4 cycles, rsp_* stable, cmd_ready=0 until the rsp_ready handshake.
REQ-042 cmd_we=1 and cmd_compute=1 -> enable_IM never asserts and the command behaves as a write.
REQ-043 Assert rst in the 2nd DRIVE_RD cycle -> all outputs are 0 in the same cycle, no rsp_valid, and the next read completes normally.
